// File: rtl/ubcd_pkg.sv
// Shared types and constants for the multi-digit display path of the universal decoder.
package ubcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP
    } scan_state_e;

    localparam int CODE_W     = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [CODE_W-1:0] BLANK_CODE = 4'h0;

    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/ubcd_lzb_mask.sv
// Leading-zero blank mask: bit i is set when digit i and every digit above it are zero.
module ubcd_lzb_mask
    import ubcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [CODE_W*NUM_DIGITS-1:0] word,
    input  logic                         lzb_en,
    output logic [NUM_DIGITS-1:0]        blank
);

    logic zero_run;

    // Walk from the most significant digit down; digit 0 always stays lit.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (word[CODE_W*i +: CODE_W] == BLANK_CODE);
            blank[i] = lzb_en && zero_run;
        end
    end

endmodule

// File: rtl/ubcd_digit_scanner.sv
// Time-multiplexes an N-digit code word onto the decoder input with one-hot digit
// select, anti-ghosting gaps, leading-zero blanking and frame-level double buffering.
module ubcd_digit_scanner
    import ubcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       load_data,
    input  logic                          lzb_en,
    output logic [3:0]                    digit_code,
    output logic                          digit_valid,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int DW = $clog2(DWELL + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    scan_state_e                         state_q, state_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [DW-1:0]                       dwell_q, dwell_d;
    logic [GW-1:0]                       gap_q, gap_d;
    logic [CODE_W*NUM_DIGITS-1:0]        shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]   active_q, active_d;
    logic [CODE_W-1:0]                   code_q, code_d;
    logic                                valid_q, valid_d;
    logic [NUM_DIGITS-1:0]               sel_q, sel_d;
    logic                                frame_q, frame_d;
    logic                                advance;
    logic [NUM_DIGITS-1:0]               blank_mask;

    // Mask is taken from the word that will be on display next cycle, so a freshly
    // latched frame is blanked correctly from its very first slot.
    ubcd_lzb_mask #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_lzb_mask (
        .word   (active_d),
        .lzb_en (lzb_en),
        .blank  (blank_mask)
    );

    always_comb begin
        shadow_d = load ? load_data : shadow_q;
        state_d  = state_q;
        idx_d    = idx_q;
        dwell_d  = '0;
        gap_d    = '0;
        active_d = active_q;
        frame_d  = 1'b0;
        advance  = 1'b0;

        if (!ena) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SHOW;
                    idx_d    = '0;
                    active_d = shadow_d;
                    frame_d  = 1'b1;
                end
                ST_SHOW: begin
                    if (dwell_q == DWELL_LAST) begin
                        if (GAP_CYCLES > 0) state_d = ST_GAP;
                        else                advance = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) advance = 1'b1;
                    else                   gap_d   = gap_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase

            // shadow_d already folds in a same-cycle load, giving the boundary bypass.
            if (advance) begin
                state_d = ST_SHOW;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    frame_d  = 1'b1;
                    active_d = shadow_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_d   = '0;
        valid_d = 1'b0;
        code_d  = BLANK_CODE;
        unique case (state_d)
            ST_SHOW: begin
                sel_d[idx_d] = 1'b1;
                valid_d      = !blank_mask[idx_d];
                code_d       = active_d[idx_d];
            end
            ST_GAP:  code_d = code_q;
            default: code_d = BLANK_CODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dwell_q  <= '0;
            gap_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
        end
    end

    assign digit_code  = code_q;
    assign digit_valid = valid_q;
    assign digit_sel   = sel_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_ubcd_digit_scanner.sv
// Directed bench: 4 digits, DWELL=3, GAP=1 main instance plus a DWELL=1, GAP=0 instance.
module tb_ubcd_digit_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        load;
    logic [15:0] load_data;
    logic        lzb_en;

    logic [3:0]  digit_code,  g0_code;
    logic        digit_valid, g0_valid;
    logic [3:0]  digit_sel,   g0_sel;
    logic [1:0]  digit_idx,   g0_idx;
    logic        frame_start, g0_frame;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ubcd_digit_scanner #(.NUM_DIGITS(4), .DWELL(3), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .load_data(load_data),
        .lzb_en(lzb_en), .digit_code(digit_code), .digit_valid(digit_valid),
        .digit_sel(digit_sel), .digit_idx(digit_idx), .frame_start(frame_start)
    );

    ubcd_digit_scanner #(.NUM_DIGITS(4), .DWELL(1), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .load_data(load_data),
        .lzb_en(lzb_en), .digit_code(g0_code), .digit_valid(g0_valid),
        .digit_sel(g0_sel), .digit_idx(g0_idx), .frame_start(g0_frame)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; load = 1'b0; load_data = 16'h0; lzb_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({digit_sel, digit_valid, digit_code, digit_idx, frame_start} !== 12'h000) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: sel=%b valid=%b code=%h idx=%0d fs=%b, want all zero",
                         k, digit_sel, digit_valid, digit_code, digit_idx, frame_start);
            end
            tick();
        end
    endtask

    // Each frame is 16 cycles: per digit 3 SHOW cycles then 1 GAP cycle.
    task automatic test_basic_scan();
        logic [3:0] want_sel, want_code;
        logic       want_valid, want_fs;
        int         d, ph;
        do_reset();
        load = 1'b1; load_data = 16'h4321; ena = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            d  = (k % 16) / 4;
            ph = k % 4;
            want_code  = 4'(d + 1);
            want_sel   = (ph < 3) ? 4'(1 << d) : 4'b0000;
            want_valid = (ph < 3);
            want_fs    = ((k % 16) == 0);
            checks++;
            if (digit_sel !== want_sel || digit_code !== want_code || digit_valid !== want_valid ||
                frame_start !== want_fs || digit_idx !== 2'(d)) begin
                errors++;
                $display("FAIL basic_scan cyc%0d: sel=%b code=%h valid=%b fs=%b idx=%0d, want sel=%b code=%h valid=%b fs=%b idx=%0d",
                         k, digit_sel, digit_code, digit_valid, frame_start, digit_idx,
                         want_sel, want_code, want_valid, want_fs, d);
            end
            tick();
        end
    endtask

    task automatic test_lzb();
        logic [3:0] codes [2][4];
        logic       valids[2][4];
        logic [3:0] want_sel;
        logic       want_valid;
        int         d, ph, f;
        // Frame 0 shows 0x0050, frame 1 shows 0x0000 (loaded mid-frame 0).
        codes[0]  = '{4'h0, 4'h5, 4'h0, 4'h0};
        valids[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
        codes[1]  = '{4'h0, 4'h0, 4'h0, 4'h0};
        valids[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        load = 1'b1; load_data = 16'h0050; ena = 1'b1; lzb_en = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            f  = k / 16;
            d  = (k % 16) / 4;
            ph = k % 4;
            want_sel   = (ph < 3) ? 4'(1 << d) : 4'b0000;
            want_valid = (ph < 3) && valids[f][d];
            checks++;
            if (digit_sel !== want_sel || digit_code !== codes[f][d] || digit_valid !== want_valid) begin
                errors++;
                $display("FAIL lzb cyc%0d: sel=%b code=%h valid=%b, want sel=%b code=%h valid=%b",
                         k, digit_sel, digit_code, digit_valid, want_sel, codes[f][d], want_valid);
            end
            if (k == 5) begin
                load = 1'b1; load_data = 16'h0000;
            end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_double_buffer();
        logic [3:0] codes [3][4];
        logic [3:0] want_sel;
        logic       want_fs;
        int         d, ph, f;
        codes[0] = '{4'h1, 4'h2, 4'h3, 4'h4};
        codes[1] = '{4'h9, 4'h9, 4'h9, 4'h9};
        codes[2] = '{4'h1, 4'h1, 4'h1, 4'h1};
        do_reset();
        load = 1'b1; load_data = 16'h4321; ena = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 48; k++) begin
            f  = k / 16;
            d  = (k % 16) / 4;
            ph = k % 4;
            want_sel = (ph < 3) ? 4'(1 << d) : 4'b0000;
            want_fs  = ((k % 16) == 0);
            checks++;
            if (digit_sel !== want_sel || digit_code !== codes[f][d] || frame_start !== want_fs) begin
                errors++;
                $display("FAIL double_buf cyc%0d: sel=%b code=%h fs=%b, want sel=%b code=%h fs=%b",
                         k, digit_sel, digit_code, frame_start, want_sel, codes[f][d], want_fs);
            end
            if (k == 5) begin
                load = 1'b1; load_data = 16'h9999;
            end else if (k == 31) begin
                load = 1'b1; load_data = 16'h1111;
            end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_ena_reset();
        do_reset();
        load = 1'b1; load_data = 16'h4321; ena = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (digit_sel !== 4'b0100 || digit_code !== 4'h3) begin
            errors++;
            $display("FAIL ena_digit2: sel=%b code=%h, want sel=0100 code=3", digit_sel, digit_code);
        end
        ena = 1'b0;
        tick();
        checks++;
        if (digit_sel !== 4'b0000 || digit_valid !== 1'b0 || digit_idx !== 2'd0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL ena_drop: sel=%b valid=%b idx=%0d fs=%b, want sel=0000 valid=0 idx=0 fs=0",
                     digit_sel, digit_valid, digit_idx, frame_start);
        end
        tick();
        ena = 1'b1;
        tick();
        checks++;
        if (frame_start !== 1'b1 || digit_sel !== 4'b0001 || digit_code !== 4'h1 || digit_valid !== 1'b1) begin
            errors++;
            $display("FAIL ena_restart: fs=%b sel=%b code=%h valid=%b, want fs=1 sel=0001 code=1 valid=1",
                     frame_start, digit_sel, digit_code, digit_valid);
        end
        tick(); tick(); tick();
        checks++;
        if (digit_sel !== 4'b0000 || digit_valid !== 1'b0 || digit_code !== 4'h1) begin
            errors++;
            $display("FAIL gap_before_rst: sel=%b valid=%b code=%h, want sel=0000 valid=0 code=1",
                     digit_sel, digit_valid, digit_code);
        end
        rst = 1'b1; load = 1'b1; load_data = 16'hFFFF;
        tick();
        rst = 1'b0; load = 1'b0; ena = 1'b0;
        checks++;
        if ({digit_sel, digit_valid, digit_code, digit_idx, frame_start} !== 12'h000) begin
            errors++;
            $display("FAIL rst_in_gap: sel=%b valid=%b code=%h idx=%0d fs=%b, want all zero",
                     digit_sel, digit_valid, digit_code, digit_idx, frame_start);
        end
        ena = 1'b1;
        tick();
        checks++;
        if (frame_start !== 1'b1 || digit_sel !== 4'b0001 || digit_code !== 4'h0) begin
            errors++;
            $display("FAIL rst_clears_shadow: fs=%b sel=%b code=%h, want fs=1 sel=0001 code=0",
                     frame_start, digit_sel, digit_code);
        end
    endtask

    task automatic test_no_gap();
        logic [3:0] want_sel;
        do_reset();
        load = 1'b1; load_data = 16'h4321; ena = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            want_sel = 4'(1 << (k % 4));
            checks++;
            if (g0_sel !== want_sel || g0_code !== 4'((k % 4) + 1) || g0_valid !== 1'b1 ||
                g0_frame !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL no_gap cyc%0d: sel=%b code=%h valid=%b fs=%b, want sel=%b code=%0d valid=1 fs=%b",
                         k, g0_sel, g0_code, g0_valid, g0_frame, want_sel, (k % 4) + 1, ((k % 4) == 0));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lzb();
        test_double_buffer();
        test_ena_reset();
        test_no_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ubcd_digit_scanner.md
Name: ubcd_digit_scanner

Overview:
- Upstream feeder for the universal decoder in multi-digit display mode.
- Holds an N-digit code word and time-multiplexes it, one 4-bit code per slot, onto the decoder's code input.
- Drives one-hot digit-select lines, inserts anti-ghosting blank gaps, and optionally blanks leading zeros.
- Updates are double-buffered so a displayed frame never tears.

Parameters:
- NUM_DIGITS, 4, digits scanned per frame (2..8).
- DWELL, 1000, clk cycles each digit is shown (>=1).
- GAP_CYCLES, 2, all-off cycles after each digit (0 = no gap).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  scan enable; low forces idle/all-off
- load  in  1  one-cycle strobe, captures load_data into shadow register
- load_data  in  4*NUM_DIGITS  digit codes, digit i at bits [4i+3:4i], digit 0 = least significant
- lzb_en  in  1  leading-zero blanking enable
- digit_code  out  4  code presented to decoder
- digit_valid  out  1  high = decoder should light segments; low = blank
- digit_sel  out  NUM_DIGITS  one-hot common-select, all zero when blank/idle
- digit_idx  out  $clog2(NUM_DIGITS)  index of current digit
- frame_start  out  1  one-cycle pulse, first SHOW cycle of digit 0

Behaviour:
- All outputs registered. On rst (sync, active-high):
  - state=IDLE, shadow=0, active=0, dwell counter=0, gap counter=0.
  - digit_code=0, digit_valid=0, digit_sel=0, digit_idx=0, frame_start=0.
  - rst overrides ena and load in the same cycle.
- Shadow register: on load, shadow <= load_data, regardless of state.
- FSM states IDLE, SHOW, GAP.
  - IDLE, ena=1: active <= (load ? load_data : shadow); go to SHOW with idx=0 next cycle; frame_start=1 in that cycle.
  - SHOW: hold for exactly DWELL cycles.
    - digit_sel = one-hot(idx); digit_code = active[idx].
    - digit_valid = 1 unless the digit is blanked.
    - After DWELL cycles: GAP if GAP_CYCLES>0, else advance directly.
  - GAP: exactly GAP_CYCLES cycles with digit_sel=0, digit_valid=0. digit_code and digit_idx hold their last values. Then advance.
- Advance:
  - idx<NUM_DIGITS-1: idx+1, SHOW.
  - idx=NUM_DIGITS-1: wrap to idx=0, SHOW, frame_start=1.
  - Frame boundary: active <= (load ? load_data : shadow). A load in the boundary cycle bypasses the shadow and is displayed in that frame.
- Frame period = NUM_DIGITS*(DWELL+GAP_CYCLES) cycles.
- ena deassert in any state: next cycle state=IDLE, digit_sel=0, digit_valid=0, idx=0. Re-enable starts a fresh frame at digit 0.
- Leading-zero blanking, evaluated combinationally on active:
  - Digit i (i>=1) is blanked when lzb_en=1, active[i]==0, and active[j]==0 for all j>i.
  - Digit 0 is never blanked.
  - A blanked digit keeps its slot timing: digit_sel stays one-hot and digit_code=0, so brightness stays uniform; only digit_valid=0.
  - lzb_en is sampled every cycle and is not frame-buffered.
- Codes 0xA–0xF pass through unmodified. Only code 0 counts as zero for blanking.
- Dwell and gap counters are sized $clog2(max+1) and reset to 0 on every state entry.

Decomposition:
- Package ubcd_pkg:
  - scan state enum (IDLE/SHOW/GAP).
  - localparam widths derived from NUM_DIGITS, shared with the top-level decoder wrapper.
  - Constant for the blank code.
- Sub-module ubcd_lzb_mask:
  - Combinational; takes active word and lzb_en, returns a NUM_DIGITS-bit blank mask.
  - Reused by the static-display path.
- Everything else stays in ubcd_digit_scanner.

Test Plan:
- Reset/idle (NUM_DIGITS=4, DWELL=3, GAP_CYCLES=1): after rst with ena=0 -> digit_sel=0, digit_valid=0, digit_code=0, frame_start never pulses.
- Basic scan: load 0x4321, ena=1, lzb_en=0.
  - Required sequence: sel 0001/code 1 x3, gap x1, 0010/2 x3, gap, 0100/3 x3, gap, 1000/4 x3, gap.
  - frame_start pulses every 16 cycles.
- Leading-zero blanking: load 0x0050, lzb_en=1.
  - Digits 3 and 2 give valid=0, code=0, sel still one-hot.
  - Digit 1 valid=1 code 5; digit 0 valid=1 code 0.
  - Load 0x0000 -> only digit 0 is valid.
- Double buffering: mid-frame load 0x9999 while 0x4321 is displayed.
  - Remaining digits of that frame show 3,4.
  - From the next frame_start, all digits show 9.
  - Load asserted exactly in the wrap cycle with 0x1111 -> that frame shows 1s.
- ena/reset mid-operation:
  - Drop ena during digit 2 SHOW -> next cycle all-off, idx=0.
  - Re-raise ena -> frame_start, digit 0 shown.
  - Assert rst during GAP with load=1 -> shadow=0, outputs zero.
- No-gap config (GAP_CYCLES=0, DWELL=1): digit_sel rotates 0001→0010→0100→1000→0001 every cycle, with frame_start every 4th cycle.
